// File: rtl/id_stage_pkg.sv
// id_stage_pkg: ISA definitions shared by fetch, decode and execute.
// Opcodes, field positions, the bubble word and operand-class helpers.
package id_stage_pkg;

  localparam logic [15:0] NOP_INSN = 16'h0000;

  localparam int OP_LSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;

  localparam logic [4:0] OP_NOP   = 5'd0;
  localparam logic [4:0] OP_HALT  = 5'd1;
  localparam logic [4:0] OP_LOAD  = 5'd2;
  localparam logic [4:0] OP_STORE = 5'd3;
  localparam logic [4:0] OP_LDIH  = 5'd8;
  localparam logic [4:0] OP_ADD   = 5'd9;
  localparam logic [4:0] OP_ADDI  = 5'd10;
  localparam logic [4:0] OP_ADDC  = 5'd11;
  localparam logic [4:0] OP_SUB   = 5'd12;
  localparam logic [4:0] OP_SUBI  = 5'd13;
  localparam logic [4:0] OP_SUBC  = 5'd14;
  localparam logic [4:0] OP_CMP   = 5'd15;
  localparam logic [4:0] OP_AND   = 5'd16;
  localparam logic [4:0] OP_OR    = 5'd17;
  localparam logic [4:0] OP_XOR   = 5'd18;
  localparam logic [4:0] OP_SLL   = 5'd19;
  localparam logic [4:0] OP_SRL   = 5'd20;
  localparam logic [4:0] OP_SLA   = 5'd21;
  localparam logic [4:0] OP_SRA   = 5'd22;
  localparam logic [4:0] OP_JUMP  = 5'd24;
  localparam logic [4:0] OP_JMPR  = 5'd25;
  localparam logic [4:0] OP_BZ    = 5'd26;
  localparam logic [4:0] OP_BNZ   = 5'd27;
  localparam logic [4:0] OP_BN    = 5'd28;
  localparam logic [4:0] OP_BNN   = 5'd29;
  localparam logic [4:0] OP_BC    = 5'd30;
  localparam logic [4:0] OP_BNC   = 5'd31;

  typedef enum logic [2:0] {
    CL_NONE,
    CL_RR,
    CL_SH,
    CL_RDI,
    CL_LD,
    CL_ST,
    CL_JMP,
    CL_BR
  } op_class_e;

  function automatic op_class_e op_class(input logic [4:0] op);
    op_class_e c;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
      OP_AND, OP_OR, OP_XOR, OP_CMP:   c = CL_RR;
      OP_SLL, OP_SRL, OP_SLA, OP_SRA:  c = CL_SH;
      OP_ADDI, OP_SUBI, OP_LDIH:       c = CL_RDI;
      OP_LOAD:                         c = CL_LD;
      OP_STORE:                        c = CL_ST;
      OP_JUMP:                         c = CL_JMP;
      OP_JMPR, OP_BZ, OP_BNZ, OP_BN,
      OP_BNN, OP_BC, OP_BNC:           c = CL_BR;
      default:                         c = CL_NONE;
    endcase
    return c;
  endfunction

  // CMP only sets flags, so it is the one ALU op that leaves rd alone.
  function automatic logic writes_rd(input logic [4:0] op);
    op_class_e c;
    c = op_class(op);
    return (c == CL_RR || c == CL_SH || c == CL_RDI || c == CL_LD)
           && op != OP_CMP;
  endfunction

  function automatic logic reads_rs1(input op_class_e c);
    return c == CL_RR || c == CL_SH || c == CL_LD || c == CL_ST;
  endfunction

  function automatic logic reads_rs2(input op_class_e c);
    return c == CL_RR;
  endfunction

  function automatic logic reads_rd(input op_class_e c);
    return c == CL_RDI || c == CL_ST || c == CL_BR;
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// id_stage_if: fetch/WB/forwarding inputs and EX-bound outputs of decode.
// master = surrounding pipeline, slave = id_stage.
interface id_stage_if;
  logic        state;
  logic [15:0] id_ir;
  logic        flush;
  logic        wb_we;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic        ex_fwd_we;
  logic [2:0]  ex_fwd_addr;
  logic [15:0] ex_fwd_data;
  logic        mem_fwd_we;
  logic [2:0]  mem_fwd_addr;
  logic [15:0] mem_fwd_data;
  logic [15:0] mem_ir;
  logic [15:0] ex_ir;
  logic [15:0] reg_A;
  logic [15:0] reg_B;
  logic [15:0] smdr;
  logic        stall;

  modport master (
    output state, id_ir, flush,
    output wb_we, wb_addr, wb_data,
    output ex_fwd_we, ex_fwd_addr, ex_fwd_data,
    output mem_fwd_we, mem_fwd_addr, mem_fwd_data,
    output mem_ir,
    input  ex_ir, reg_A, reg_B, smdr, stall
  );

  modport slave (
    input  state, id_ir, flush,
    input  wb_we, wb_addr, wb_data,
    input  ex_fwd_we, ex_fwd_addr, ex_fwd_data,
    input  mem_fwd_we, mem_fwd_addr, mem_fwd_data,
    input  mem_ir,
    output ex_ir, reg_A, reg_B, smdr, stall
  );
endinterface

// File: rtl/id_stage_gr_file_8x16.sv
// gr_file_8x16: 8x16 register file, one write port, three async reads.
// Ports: clock/reset, we/waddr/wdata, ra1..ra3 -> rdata1..rdata3.
module gr_file_8x16 (
  input  logic        clock,
  input  logic        reset,
  input  logic        we,
  input  logic [2:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [2:0]  ra1,
  input  logic [2:0]  ra2,
  input  logic [2:0]  ra3,
  output logic [15:0] rdata1,
  output logic [15:0] rdata2,
  output logic [15:0] rdata3
);

  logic [15:0] gr [8];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) gr[i] <= '0;
    end else if (we) begin
      gr[waddr] <= wdata;
    end
  end

  // A write landing this cycle is visible to readers immediately.
  assign rdata1 = (we && waddr == ra1) ? wdata : gr[ra1];
  assign rdata2 = (we && waddr == ra2) ? wdata : gr[ra2];
  assign rdata3 = (we && waddr == ra3) ? wdata : gr[ra3];

endmodule

// File: rtl/id_stage.sv
// id_stage: decode stage - operand build, register file, hazard stall.
// Ports: clock, reset, io (id_stage_if.slave). Option: ID_FORWARD_EN.
module id_stage
  import id_stage_pkg::*;
#(
  parameter logic [15:0] NOP_WORD = NOP_INSN
) (
  input logic        clock,
  input logic        reset,
  id_stage_if.slave  io
);

  logic [4:0]  op, ex_op, mem_op;
  logic [2:0]  rd, rs1, rs2, ex_rd, mem_rd;
  op_class_e   cls;
  logic [15:0] gr_rs1, gr_rs2, gr_rd;
  logic [15:0] v_rs1, v_rs2, v_rd;
  logic [15:0] a_nx, b_nx, s_nx;
  logic [7:0]  src_mask;
  logic        hazard;
  logic        unused_fwd;

  assign op     = io.id_ir[OP_LSB +: 5];
  assign rd     = io.id_ir[RD_LSB +: 3];
  assign rs1    = io.id_ir[RS1_LSB +: 3];
  assign rs2    = io.id_ir[RS2_LSB +: 3];
  assign ex_op  = io.ex_ir[OP_LSB +: 5];
  assign ex_rd  = io.ex_ir[RD_LSB +: 3];
  assign mem_op = io.mem_ir[OP_LSB +: 5];
  assign mem_rd = io.mem_ir[RD_LSB +: 3];
  assign cls    = op_class(op);

  gr_file_8x16 u_gr (
    .clock  (clock),
    .reset  (reset),
    .we     (io.state & io.wb_we),
    .waddr  (io.wb_addr),
    .wdata  (io.wb_data),
    .ra1    (rs1),
    .ra2    (rs2),
    .ra3    (rd),
    .rdata1 (gr_rs1),
    .rdata2 (gr_rs2),
    .rdata3 (gr_rd)
  );

`ifdef ID_FORWARD_EN
  function automatic logic [15:0] pick(
    input logic [2:0]  r,
    input logic [15:0] base,
    input logic        ew,
    input logic [2:0]  ea,
    input logic [15:0] ed,
    input logic        mw,
    input logic [2:0]  ma,
    input logic [15:0] md
  );
    if (ew && ea == r) return ed;
    if (mw && ma == r) return md;
    return base;
  endfunction

  assign v_rs1 = pick(rs1, gr_rs1,
    io.ex_fwd_we, io.ex_fwd_addr, io.ex_fwd_data,
    io.mem_fwd_we, io.mem_fwd_addr, io.mem_fwd_data);
  assign v_rs2 = pick(rs2, gr_rs2,
    io.ex_fwd_we, io.ex_fwd_addr, io.ex_fwd_data,
    io.mem_fwd_we, io.mem_fwd_addr, io.mem_fwd_data);
  assign v_rd  = pick(rd, gr_rd,
    io.ex_fwd_we, io.ex_fwd_addr, io.ex_fwd_data,
    io.mem_fwd_we, io.mem_fwd_addr, io.mem_fwd_data);
  assign unused_fwd = ^io.mem_ir;
`else
  assign v_rs1 = gr_rs1;
  assign v_rs2 = gr_rs2;
  assign v_rd  = gr_rd;
  assign unused_fwd = ^{io.ex_fwd_we, io.ex_fwd_addr,
    io.ex_fwd_data, io.mem_fwd_we, io.mem_fwd_addr,
    io.mem_fwd_data, io.mem_ir[7:0]};
`endif

  // One bit per register the current instruction actually reads.
  always_comb begin
    src_mask = '0;
    if (reads_rs1(cls)) src_mask[rs1] = 1'b1;
    if (reads_rs2(cls)) src_mask[rs2] = 1'b1;
    if (reads_rd(cls))  src_mask[rd]  = 1'b1;
  end

`ifdef ID_FORWARD_EN
  assign hazard = (ex_op == OP_LOAD) && src_mask[ex_rd];
`else
  assign hazard =
    (writes_rd(ex_op) && src_mask[ex_rd]) ||
    (writes_rd(mem_op) && src_mask[mem_rd]);
`endif

  assign io.stall = hazard && !io.flush;

  always_comb begin
    a_nx = '0;
    b_nx = '0;
    s_nx = '0;
    unique case (1'b1)
      cls == CL_RR: begin
        a_nx = v_rs1;
        b_nx = v_rs2;
      end
      cls == CL_SH || cls == CL_LD: begin
        a_nx = v_rs1;
        b_nx = {12'b0, io.id_ir[3:0]};
      end
      cls == CL_ST: begin
        a_nx = v_rs1;
        b_nx = {12'b0, io.id_ir[3:0]};
        s_nx = v_rd;
      end
      cls == CL_RDI || cls == CL_BR: begin
        a_nx = v_rd;
        b_nx = {8'b0, io.id_ir[7:0]};
      end
      cls == CL_JMP: begin
        b_nx = {8'b0, io.id_ir[7:0]};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io.ex_ir <= NOP_WORD;
      io.reg_A <= '0;
      io.reg_B <= '0;
      io.smdr  <= '0;
    end else if (io.state) begin
      if (io.flush || hazard) begin
        io.ex_ir <= NOP_WORD;
        io.reg_A <= '0;
        io.reg_B <= '0;
        io.smdr  <= '0;
      end else begin
        io.ex_ir <= io.id_ir;
        io.reg_A <= a_nx;
        io.reg_B <= b_nx;
        io.smdr  <= s_nx;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: directed + random checks of id_stage against a
// behavioural model of the decode rules.
module tb_id_stage;
  import id_stage_pkg::*;

  logic clock;
  logic reset;

  id_stage_if bus ();

  id_stage dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int checks = 0;
  int errors = 0;

  logic [15:0] gr_m [8];
  logic [15:0] ex_m, a_m, b_m, s_m;

  task automatic check(input string tag,
                       input logic [15:0] got,
                       input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] rr(input logic [4:0] o,
    input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2);
    return {o, d, 1'b0, s1, 1'b0, s2};
  endfunction

  function automatic logic [15:0] ri4(input logic [4:0] o,
    input logic [2:0] d, input logic [2:0] s1, input logic [3:0] i);
    return {o, d, 1'b0, s1, i};
  endfunction

  function automatic logic writes(input logic [4:0] o);
    return o inside {OP_LOAD, OP_LDIH, OP_ADD, OP_ADDI, OP_ADDC,
      OP_SUB, OP_SUBI, OP_SUBC, OP_AND, OP_OR, OP_XOR,
      OP_SLL, OP_SRL, OP_SLA, OP_SRA};
  endfunction

  function automatic logic [15:0] val(input logic [2:0] r);
    logic [15:0] v;
    v = gr_m[r];
    if (bus.wb_we && bus.wb_addr == r) v = bus.wb_data;
`ifdef ID_FORWARD_EN
    if (bus.mem_fwd_we && bus.mem_fwd_addr == r) v = bus.mem_fwd_data;
    if (bus.ex_fwd_we && bus.ex_fwd_addr == r) v = bus.ex_fwd_data;
`endif
    return v;
  endfunction

  task automatic decode(output logic [15:0] a, output logic [15:0] b,
                        output logic [15:0] s, output logic [7:0] used);
    logic [15:0] ir;
    logic [4:0]  o;
    logic [2:0]  d, s1, s2;
    ir = bus.id_ir;
    o  = ir[15:11];
    d  = ir[10:8];
    s1 = ir[6:4];
    s2 = ir[2:0];
    a = '0; b = '0; s = '0; used = '0;
    if (o inside {OP_ADD, OP_ADDC, OP_SUB, OP_SUBC,
                  OP_AND, OP_OR, OP_XOR, OP_CMP}) begin
      a = val(s1); b = val(s2);
      used[s1] = 1'b1; used[s2] = 1'b1;
    end else if (o inside {OP_SLL, OP_SRL, OP_SLA, OP_SRA, OP_LOAD}) begin
      a = val(s1); b = {12'h0, ir[3:0]};
      used[s1] = 1'b1;
    end else if (o == OP_STORE) begin
      a = val(s1); b = {12'h0, ir[3:0]}; s = val(d);
      used[s1] = 1'b1; used[d] = 1'b1;
    end else if (o inside {OP_ADDI, OP_SUBI, OP_LDIH, OP_JMPR, OP_BZ,
                           OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC}) begin
      a = val(d); b = {8'h0, ir[7:0]};
      used[d] = 1'b1;
    end else if (o == OP_JUMP) begin
      b = {8'h0, ir[7:0]};
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) gr_m[i] = '0;
    ex_m = 16'h0000; a_m = '0; b_m = '0; s_m = '0;
  endtask

  task automatic idle();
    bus.state = 1'b1; bus.id_ir = 16'h0000; bus.flush = 1'b0;
    bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
    bus.ex_fwd_we = 1'b0; bus.ex_fwd_addr = '0; bus.ex_fwd_data = '0;
    bus.mem_fwd_we = 1'b0; bus.mem_fwd_addr = '0; bus.mem_fwd_data = '0;
    bus.mem_ir = 16'h0000;
  endtask

  // One clock: check stall on current inputs, then the registered result.
  task automatic step();
    logic [15:0] a, b, s;
    logic [7:0]  used;
    logic        st;
    decode(a, b, s, used);
`ifdef ID_FORWARD_EN
    st = (ex_m[15:11] == OP_LOAD) && used[ex_m[10:8]];
`else
    st = (writes(ex_m[15:11]) && used[ex_m[10:8]]) ||
         (writes(bus.mem_ir[15:11]) && used[bus.mem_ir[10:8]]);
`endif
    st = st && !bus.flush;
    #1;
    check("stall", {15'h0, bus.stall}, {15'h0, st});
    @(posedge clock);
    if (bus.state) begin
      if (bus.wb_we) gr_m[bus.wb_addr] = bus.wb_data;
      if (bus.flush || st) begin
        ex_m = 16'h0000; a_m = '0; b_m = '0; s_m = '0;
      end else begin
        ex_m = bus.id_ir; a_m = a; b_m = b; s_m = s;
      end
    end
    #1;
    check("ex_ir", bus.ex_ir, ex_m);
    check("reg_A", bus.reg_A, a_m);
    check("reg_B", bus.reg_B, b_m);
    check("smdr", bus.smdr, s_m);
  endtask

  initial begin
    reset = 1'b1;
    idle();
    model_reset();
    #2;
    check("rst_ex_ir", bus.ex_ir, 16'h0000);
    check("rst_A", bus.reg_A, 16'h0000);
    check("rst_B", bus.reg_B, 16'h0000);
    check("rst_smdr", bus.smdr, 16'h0000);
    check("rst_stall", {15'h0, bus.stall}, 16'h0000);
    #10;
    reset = 1'b0;

    bus.wb_we = 1'b1; bus.wb_addr = 3'd1; bus.wb_data = 16'h0005;
    step();
    bus.wb_addr = 3'd2; bus.wb_data = 16'h0003;
    step();
    bus.wb_we = 1'b0;
    bus.id_ir = rr(OP_ADD, 3'd3, 3'd1, 3'd2);
    step();
    check("add_A", bus.reg_A, 16'h0005);
    check("add_B", bus.reg_B, 16'h0003);
    check("add_ir", bus.ex_ir, rr(OP_ADD, 3'd3, 3'd1, 3'd2));

    bus.id_ir = ri4(OP_LOAD, 3'd4, 3'd1, 4'd2);
    step();
    bus.id_ir = rr(OP_ADD, 3'd5, 3'd4, 3'd1);
    #1;
    check("lu_stall", {15'h0, bus.stall}, 16'h0001);
    step();
    check("lu_bubble_ir", bus.ex_ir, 16'h0000);
    check("lu_bubble_A", bus.reg_A, 16'h0000);
    check("lu_bubble_B", bus.reg_B, 16'h0000);
    step();
    check("lu_after_ir", bus.ex_ir, rr(OP_ADD, 3'd5, 3'd4, 3'd1));

    bus.id_ir = rr(OP_ADD, 3'd6, 3'd1, 3'd2);
    bus.ex_fwd_we = 1'b1; bus.ex_fwd_addr = 3'd1;
    bus.ex_fwd_data = 16'hBEEF;
    bus.mem_ir = rr(OP_ADD, 3'd1, 3'd0, 3'd0);
`ifdef ID_FORWARD_EN
    step();
    check("fwd_A", bus.reg_A, 16'hBEEF);
`else
    #1;
    check("nofwd_stall", {15'h0, bus.stall}, 16'h0001);
    step();
`endif
    bus.ex_fwd_we = 1'b0;
    bus.mem_ir = 16'h0000;
    step();

    bus.id_ir = rr(OP_ADD, 3'd7, 3'd1, 3'd2);
    bus.wb_we = 1'b1; bus.wb_addr = 3'd2; bus.wb_data = 16'h1234;
    step();
    check("byp_B", bus.reg_B, 16'h1234);
    check("byp_A", bus.reg_A, 16'h0005);
    bus.wb_we = 1'b0;
    step();
    check("wb_kept_B", bus.reg_B, 16'h1234);

    bus.id_ir = ri4(OP_LOAD, 3'd4, 3'd1, 4'd0);
    step();
    bus.id_ir = rr(OP_ADD, 3'd5, 3'd4, 3'd1);
    bus.flush = 1'b1;
    #1;
    check("flush_stall", {15'h0, bus.stall}, 16'h0000);
    step();
    check("flush_ir", bus.ex_ir, 16'h0000);
    bus.flush = 1'b0;
    step();

    for (int n = 0; n < 400; n++) begin
      bus.state = ($urandom_range(0, 7) != 0);
      bus.id_ir = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bus.id_ir[15:11] = OP_LOAD;
      bus.flush = ($urandom_range(0, 7) == 0);
      bus.wb_we = 1'($urandom);
      bus.wb_addr = 3'($urandom);
      bus.wb_data = 16'($urandom);
      bus.ex_fwd_we = 1'($urandom);
      bus.ex_fwd_addr = 3'($urandom);
      bus.ex_fwd_data = 16'($urandom);
      bus.mem_fwd_we = 1'($urandom);
      bus.mem_fwd_addr = 3'($urandom);
      bus.mem_fwd_data = 16'($urandom);
      bus.mem_ir = 16'($urandom);
      step();
    end

    idle();
    step();
    bus.id_ir = rr(OP_SUB, 3'd1, 3'd2, 3'd3);
    step();
    check("sub_ir", bus.ex_ir, rr(OP_SUB, 3'd1, 3'd2, 3'd3));
    bus.id_ir = 16'h0000;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_ir", bus.ex_ir, 16'h0000);
    check("mid_rst_A", bus.reg_A, 16'h0000);
    check("mid_rst_B", bus.reg_B, 16'h0000);
    #1;
    reset = 1'b0;
    model_reset();
    bus.id_ir = rr(OP_ADD, 3'd0, 3'd1, 3'd2);
    step();
    check("gr1_zero", bus.reg_A, 16'h0000);
    check("gr2_zero", bus.reg_B, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
